// File: rtl/ws2812b_tx.sv
// WS2812B one-wire serializer: GRB pixels from a valid/ready stream, MSB first, NRZ bit timing plus latch gap.
// Optional WS2812B_TX_BRIGHTNESS_EN adds a per-frame brightness input that scales each channel on load.
module ws2812b_tx #(
  parameter int NUM_LEDS     = 8,
  parameter int T0H          = 35,
  parameter int T1H          = 90,
  parameter int TBIT         = 125,
  parameter int RESET_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
`ifdef WS2812B_TX_BRIGHTNESS_EN
  input  logic [7:0]  brightness,
`endif
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int CW = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam int GW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] T0H_C   = CW'(T0H);
  localparam logic [CW-1:0] T1H_C   = CW'(T1H);
  localparam logic [CW-1:0] TBIT_M1 = CW'(TBIT - 1);
  localparam logic [GW-1:0] GAP_M1  = GW'(RESET_CYCLES - 1);
  localparam logic [15:0]   NUM_C   = 16'(NUM_LEDS);

  typedef enum logic [1:0] {IDLE, FIRST, BIT, LATCH} state_t;

  state_t        state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic [23:0]   pf_q, pf_d;
  logic          pf_full_q, pf_full_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   pix_left_q, pix_left_d;
  logic [15:0]   fetched_q, fetched_d;
  logic          dout_d, frame_done_d, underrun_d;
  logic          start_ok, accept, last_tick;
  logic [23:0]   px_in;

  assign start_ok  = (state_q == IDLE) && start && !frame_done;
  assign last_tick = (state_q == BIT) && (bit_cnt_q == TBIT_M1) && (bit_idx_q == 5'd0);
  assign busy      = (state_q != IDLE);
  // The final tick of a pixel belongs to the prefetch transfer, so no new fill is offered then.
  assign pix_ready = busy && ((state_q == FIRST) ||
                     ((state_q == BIT) && !pf_full_q && (fetched_q < NUM_C) && !last_tick));
  assign accept    = pix_valid && pix_ready;

`ifdef WS2812B_TX_BRIGHTNESS_EN
  logic [7:0] bright_q;

  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = ({8'd0, c} * {8'd0, b}) + {8'd0, c};
    return 8'(p >> 8);
  endfunction

  assign px_in = {scale_ch(pix_data[23:16], bright_q),
                  scale_ch(pix_data[15:8],  bright_q),
                  scale_ch(pix_data[7:0],   bright_q)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      bright_q <= 8'd0;
    else if (start_ok) bright_q <= brightness;
  end
`else
  assign px_in = pix_data;
`endif

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    pf_d         = pf_q;
    pf_full_d    = pf_full_q;
    bit_idx_d    = bit_idx_q;
    bit_cnt_d    = bit_cnt_q;
    gap_d        = gap_q;
    pix_left_d   = pix_left_q;
    fetched_d    = fetched_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    dout_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d    = FIRST;
          pix_left_d = NUM_C;
          fetched_d  = 16'd0;
          pf_full_d  = 1'b0;
        end
      end
      FIRST: begin
        if (accept) begin
          shift_d    = px_in;
          bit_idx_d  = 5'd23;
          bit_cnt_d  = '0;
          pix_left_d = pix_left_q - 16'd1;
          fetched_d  = fetched_q + 16'd1;
          state_d    = BIT;
        end
      end
      BIT: begin
        if (accept) begin
          pf_d      = px_in;
          pf_full_d = 1'b1;
          fetched_d = fetched_q + 16'd1;
        end
        if (bit_cnt_q == TBIT_M1) begin
          bit_cnt_d = '0;
          if (bit_idx_q != 5'd0) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_idx_d = bit_idx_q - 5'd1;
          end else if (pix_left_q == 16'd0) begin
            state_d = LATCH;
            gap_d   = '0;
          end else if (pf_full_q) begin
            shift_d    = pf_q;
            pf_full_d  = 1'b0;
            bit_idx_d  = 5'd23;
            pix_left_d = pix_left_q - 16'd1;
          end else begin
            underrun_d = 1'b1;
            state_d    = LATCH;
            gap_d      = '0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (gap_q == GAP_M1) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the next-cycle bit state so the registered dout lines up with bit_cnt.
    dout_d = (state_d == BIT) && (bit_cnt_d < (shift_d[23] ? T1H_C : T0H_C));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      pf_q       <= '0;
      pf_full_q  <= 1'b0;
      bit_idx_q  <= '0;
      bit_cnt_q  <= '0;
      gap_q      <= '0;
      pix_left_q <= '0;
      fetched_q  <= '0;
      dout       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      pf_q       <= pf_d;
      pf_full_q  <= pf_full_d;
      bit_idx_q  <= bit_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_q      <= gap_d;
      pix_left_q <= pix_left_d;
      fetched_q  <= fetched_d;
      dout       <= dout_d;
      frame_done <= frame_done_d;
      underrun   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_ws2812b_tx.sv
// Directed bench for ws2812b_tx: a line monitor decodes pulse widths back into GRB words and gap timing.
module tb_ws2812b_tx;

  localparam int NUM_LEDS     = 3;
  localparam int T0H          = 35;
  localparam int T1H          = 90;
  localparam int TBIT         = 125;
  localparam int RESET_CYCLES = 5000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready, dout, busy, frame_done, underrun;
`ifdef WS2812B_TX_BRIGHTNESS_EN
  logic [7:0]  brightness;
`endif

  int checks = 0;
  int fails  = 0;

  int cyc = 0, last_rise = -1, rises = 0, spacing_err = 0, bad_width = 0;
  int bits_rx = 0, fd_cnt = 0, ur_cnt = 0, accepts = 0;
  int t_fall = 0, t_fd = 0, t_ur = 0;
  logic [23:0] sh = '0;
  logic [23:0] cap[$];

  always #5 clk = ~clk;

  ws2812b_tx #(
    .NUM_LEDS(NUM_LEDS), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .RESET_CYCLES(RESET_CYCLES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
`ifdef WS2812B_TX_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_ready(pix_ready),
    .dout(dout),
    .busy(busy),
    .frame_done(frame_done),
    .underrun(underrun)
  );

  // Line monitor: stats restart whenever a frame request is about to be taken.
  initial begin
    logic dout_prev;
    logic bitv;
    int   w;
    dout_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n && start && !busy && !frame_done) begin
        last_rise = -1; rises = 0; spacing_err = 0; bad_width = 0; bits_rx = 0;
        fd_cnt = 0; ur_cnt = 0; accepts = 0; sh = '0; cap.delete();
      end
      if (pix_valid && pix_ready) accepts++;
      if (dout && !dout_prev) begin
        if (last_rise >= 0 && (cyc - last_rise) != TBIT) spacing_err++;
        last_rise = cyc;
        rises++;
      end
      if (!dout && dout_prev) begin
        w      = cyc - last_rise;
        t_fall = cyc;
        bitv   = 1'b0;
        if (w == T1H)      bitv = 1'b1;
        else if (w != T0H) bad_width++;
        sh = {sh[22:0], bitv};
        bits_rx++;
        if (bits_rx % 24 == 0) cap.push_back(sh);
      end
      if (frame_done) begin fd_cnt++; t_fd = cyc; end
      if (underrun)   begin ur_cnt++; t_ur = cyc; end
      dout_prev = dout;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sync_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    sync_drive();
    start = 1'b0;
  endtask

  task automatic send_pixel(input logic [23:0] px, input string tag);
    int n;
    logic ok;
    pix_data  = px;
    pix_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 6000) begin
      @(negedge clk);
      if (pix_ready) ok = 1'b1;
      n++;
    end
    check_output(tag, 32'(ok), 32'd1);
    if (ok) sync_drive();
  endtask

  task automatic wait_frame_done(input string tag);
    int n;
    logic ok;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20000) begin
      @(negedge clk);
      if (frame_done) ok = 1'b1;
      n++;
    end
    check_output(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_words(input logic [23:0] w0, input logic [23:0] w1, input logic [23:0] w2,
                             input string tag);
    logic [23:0] got[3];
    check_output({tag, "_count"}, 32'(cap.size()), 32'd3);
    for (int i = 0; i < 3; i++) got[i] = (i < cap.size()) ? cap[i] : 24'hxxxxxx;
    check_output({tag, "_w0"}, 32'(got[0]), 32'(w0));
    check_output({tag, "_w1"}, 32'(got[1]), 32'(w1));
    check_output({tag, "_w2"}, 32'(got[2]), 32'(w2));
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    start     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 24'd0;
`ifdef WS2812B_TX_BRIGHTNESS_EN
    brightness = 8'd255;
`endif
    repeat (3) @(negedge clk);
    check_output("rst_dout",       32'(dout),       32'd0);
    check_output("rst_busy",       32'(busy),       32'd0);
    check_output("rst_pix_ready",  32'(pix_ready),  32'd0);
    check_output("rst_frame_done", 32'(frame_done), 32'd0);
    check_output("rst_underrun",   32'(underrun),   32'd0);
    sync_drive();
    reset_n = 1'b1;
    repeat (2) sync_drive();

    // Full three-pixel frame, a fourth pixel offered, and a start pulse while busy.
    $display("[TB] full frame");
    pulse_start();
    send_pixel(24'hFF00AA, "f1_px0_timeout");
    send_pixel(24'h010203, "f1_px1_timeout");
    send_pixel(24'h808080, "f1_px2_timeout");
    pix_data = 24'h123456;
    sync_drive();
    check_output("f1_busy_mid", 32'(busy), 32'd1);
    pulse_start();
    wait_frame_done("f1_done_timeout");
    pix_valid = 1'b0;
    check_output("f1_busy_at_done", 32'(busy), 32'd0);
    check_output("f1_gap_cycles", 32'(t_fd - t_fall), 32'(TBIT - T0H + RESET_CYCLES));
    start = 1'b1;
    sync_drive();
    start = 1'b0;
    @(negedge clk);
    check_output("f1_start_on_done_ignored", 32'(busy), 32'd0);
    check_output("f1_done_width", 32'(frame_done), 32'd0);
    check_output("f1_done_count", 32'(fd_cnt), 32'd1);
    check_output("f1_bits", 32'(bits_rx), 32'd72);
    check_output("f1_spacing_err", 32'(spacing_err), 32'd0);
    check_output("f1_bad_width", 32'(bad_width), 32'd0);
    check_output("f1_accepts", 32'(accepts), 32'd3);
    check_output("f1_underruns", 32'(ur_cnt), 32'd0);
    check_words(24'hFF00AA, 24'h010203, 24'h808080, "f1");

    // Underrun: only the first pixel is ever offered.
    $display("[TB] underrun frame");
    sync_drive();
    pulse_start();
    send_pixel(24'hFF00AA, "ur_px0_timeout");
    pix_valid = 1'b0;
    wait_frame_done("ur_done_timeout");
    @(negedge clk);
    check_output("ur_count", 32'(ur_cnt), 32'd1);
    check_output("ur_bits", 32'(bits_rx), 32'd24);
    check_output("ur_after_last_fall", 32'(t_ur - t_fall), 32'(TBIT - T0H));
    check_output("ur_gap_to_done", 32'(t_fd - t_ur), 32'(RESET_CYCLES));
    check_output("ur_done_count", 32'(fd_cnt), 32'd1);
    check_output("ur_word", 32'((cap.size() > 0) ? cap[0] : 24'hxxxxxx), 32'h00FF00AA);

    // Reset during bit 10 of the first pixel.
    $display("[TB] reset mid-frame");
    sync_drive();
    pulse_start();
    send_pixel(24'h0A0B0C, "rm_px0_timeout");
    pix_valid = 1'b0;
    n = 0;
    while (rises < 11 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_output("rm_bit10_reached", 32'(rises >= 11), 32'd1);
    check_output("rm_dout_high_before", 32'(dout), 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("rm_dout_now", 32'(dout), 32'd0);
    check_output("rm_busy_now", 32'(busy), 32'd0);
    repeat (2) sync_drive();
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    check_output("rm_no_frame_done", 32'(fd_cnt), 32'd0);
    check_output("rm_idle_dout", 32'(dout), 32'd0);

    // Normal frame after the aborted one; last bit is a 1, so the trailing low is shorter.
    $display("[TB] frame after reset");
    sync_drive();
    pulse_start();
    send_pixel(24'h0A0B0C, "f2_px0_timeout");
    send_pixel(24'h5A5A5A, "f2_px1_timeout");
    send_pixel(24'h000001, "f2_px2_timeout");
    pix_valid = 1'b0;
    wait_frame_done("f2_done_timeout");
    check_output("f2_gap_cycles", 32'(t_fd - t_fall), 32'(TBIT - T1H + RESET_CYCLES));
    check_output("f2_bits", 32'(bits_rx), 32'd72);
    check_output("f2_spacing_err", 32'(spacing_err), 32'd0);
    check_output("f2_bad_width", 32'(bad_width), 32'd0);
    check_words(24'h0A0B0C, 24'h5A5A5A, 24'h000001, "f2");

`ifdef WS2812B_TX_BRIGHTNESS_EN
    // brightness 127 multiplies by 128/256; it is sampled at start and ignored once the frame runs.
    $display("[TB] brightness frame");
    sync_drive();
    brightness = 8'd127;
    pulse_start();
    brightness = 8'd255;
    send_pixel(24'hFF8040, "br_px0_timeout");
    send_pixel(24'h000000, "br_px1_timeout");
    send_pixel(24'hFFFFFF, "br_px2_timeout");
    pix_valid = 1'b0;
    wait_frame_done("br_done_timeout");
    check_words(24'h7F4020, 24'h000000, 24'h7F7F7F, "br");
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
